// File: rtl/parking_gate_if.sv
// Entry/exit signal bundle between the lot controller and its environment.
// The controller takes the slave side. The sensors and slot finder take the master side.
interface parking_gate_if;
   logic        entry_req;
   logic [3:0]  free_idx;
   logic        exit_valid;
   logic [3:0]  exit_slot;
   logic [14:0] cars;
   logic        entry_gate_open;
   logic [3:0]  assigned_slot;
   logic        assign_valid;
   logic        full;
   logic [3:0]  occupied_count;
   logic        exit_err;

   modport slave (
      input  entry_req, free_idx, exit_valid, exit_slot,
      output cars, entry_gate_open, assigned_slot, assign_valid, full,
             occupied_count, exit_err
   );

   modport master (
      output entry_req, free_idx, exit_valid, exit_slot,
      input  cars, entry_gate_open, assigned_slot, assign_valid, full,
             occupied_count, exit_err
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Entry/exit controller for a 15-slot lot. It owns the occupancy vector,
// admits one car per entry-sensor assertion, and times the entry barrier.
module parking_gate_ctrl #(
   parameter int unsigned GATE_OPEN_CYCLES = 8,
   parameter int unsigned CNT_W            = 8
) (
   input  logic           clk,
   input  logic           rst,
   parking_gate_if.slave  bus
);

   localparam logic [3:0] NO_SLOT = 4'd15;

   typedef enum logic [1:0] {IDLE, GATE_OPEN, WAIT_CLEAR} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [14:0]        cars_q, cars_d;
   logic [3:0]         count_q, count_d;
   logic [3:0]         slot_q, slot_d;
   logic               assign_valid_q, assign_valid_d;
   logic               gate_q, gate_d;
   logic               exit_err_q, exit_err_d;

   logic [15:0]        cars_ext_c;
   logic [15:0]        set_mask_c, clr_mask_c;
   logic               alloc_c, exit_ok_c;

   // Slot 15 reads as permanently occupied, so index 15 never allocates.
   assign cars_ext_c = {1'b1, cars_q};
   assign set_mask_c = 16'(1) << bus.free_idx;
   assign clr_mask_c = 16'(1) << bus.exit_slot;
   assign alloc_c    = (state_q == IDLE) && bus.entry_req && !cars_ext_c[bus.free_idx];
   assign exit_ok_c  = bus.exit_valid && (bus.exit_slot != NO_SLOT) && cars_ext_c[bus.exit_slot];

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      cars_d         = cars_q;
      count_d        = count_q;
      slot_d         = slot_q;
      assign_valid_d = 1'b0;
      exit_err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (alloc_c) begin
               state_d        = GATE_OPEN;
               timer_d        = CNT_W'(GATE_OPEN_CYCLES - 1);
               slot_d         = bus.free_idx;
               assign_valid_d = 1'b1;
               cars_d         = cars_d | set_mask_c[14:0];
            end
         end
         GATE_OPEN: begin
            if (timer_q == '0) state_d = WAIT_CLEAR;
            else               timer_d = timer_q - CNT_W'(1);
         end
         WAIT_CLEAR: begin
            if (!bus.entry_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Exits are processed every cycle, whatever the admission state.
      if (exit_ok_c)           cars_d     = cars_d & ~clr_mask_c[14:0];
      else if (bus.exit_valid) exit_err_d = 1'b1;

      case ({alloc_c, exit_ok_c})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase

      gate_d = (state_d == GATE_OPEN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         cars_q         <= '0;
         count_q        <= '0;
         slot_q         <= NO_SLOT;
         assign_valid_q <= 1'b0;
         gate_q         <= 1'b0;
         exit_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         cars_q         <= cars_d;
         count_q        <= count_d;
         slot_q         <= slot_d;
         assign_valid_q <= assign_valid_d;
         gate_q         <= gate_d;
         exit_err_q     <= exit_err_d;
      end
   end

   assign bus.cars            = cars_q;
   assign bus.entry_gate_open = gate_q;
   assign bus.assigned_slot   = slot_q;
   assign bus.assign_valid    = assign_valid_q;
   assign bus.full            = &cars_q;
   assign bus.occupied_count  = count_q;
   assign bus.exit_err        = exit_err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl. Each comparison is an immediate
// assertion against a hand-computed value.
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   gate_cnt;
   int   av_cnt;

   parking_gate_if bus_if ();

   parking_gate_ctrl #(.GATE_OPEN_CYCLES(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drop the sensor and let any admission run through to IDLE.
   task automatic settle();
      bus_if.entry_req  = 1'b0;
      bus_if.exit_valid = 1'b0;
      repeat (10) tick();
   endtask

   task automatic admit(input logic [3:0] idx);
      bus_if.entry_req = 1'b1;
      bus_if.free_idx  = idx;
      tick();
      settle();
   endtask

   initial begin
      rst               = 1'b1;
      bus_if.entry_req  = 1'b0;
      bus_if.free_idx   = 4'd0;
      bus_if.exit_valid = 1'b0;
      bus_if.exit_slot  = 4'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_cars",   32'(bus_if.cars), 32'h0);
      chk("rst_count",  32'(bus_if.occupied_count), 32'd0);
      chk("rst_slot",   32'(bus_if.assigned_slot), 32'd15);
      chk("rst_av",     32'(bus_if.assign_valid), 32'd0);
      chk("rst_gate",   32'(bus_if.entry_gate_open), 32'd0);
      chk("rst_err",    32'(bus_if.exit_err), 32'd0);
      chk("rst_full",   32'(bus_if.full), 32'd0);

      // First admission, with the sensor held high for 20 cycles.
      bus_if.entry_req = 1'b1;
      bus_if.free_idx  = 4'd0;
      tick();
      chk("a0_av",    32'(bus_if.assign_valid), 32'd1);
      chk("a0_slot",  32'(bus_if.assigned_slot), 32'd0);
      chk("a0_cars",  32'(bus_if.cars), 32'h0001);
      chk("a0_count", 32'(bus_if.occupied_count), 32'd1);
      bus_if.free_idx = 4'd1;
      gate_cnt = 32'(bus_if.entry_gate_open);
      av_cnt   = 0;
      for (int i = 0; i < 19; i++) begin
         tick();
         gate_cnt += 32'(bus_if.entry_gate_open);
         av_cnt   += 32'(bus_if.assign_valid);
      end
      chk("a0_gate_cycles", 32'(gate_cnt), 32'd8);
      chk("a0_no_realloc",  32'(av_cnt), 32'd0);
      chk("a0_cars_hold",   32'(bus_if.cars), 32'h0001);
      bus_if.entry_req = 1'b0;
      tick();
      tick();

      // A fresh sensor pulse after the release must allocate again.
      for (int i = 1; i < 15; i++) begin
         bus_if.entry_req = 1'b1;
         bus_if.free_idx  = 4'(i);
         tick();
         chk("fill_av",   32'(bus_if.assign_valid), 32'd1);
         chk("fill_slot", 32'(bus_if.assigned_slot), 32'(i));
         settle();
      end
      chk("full_cars",  32'(bus_if.cars), 32'h7FFF);
      chk("full_flag",  32'(bus_if.full), 32'd1);
      chk("full_count", 32'(bus_if.occupied_count), 32'd15);

      bus_if.entry_req = 1'b1;
      bus_if.free_idx  = 4'd15;
      tick();
      chk("lotfull_av",   32'(bus_if.assign_valid), 32'd0);
      tick();
      chk("lotfull_gate", 32'(bus_if.entry_gate_open), 32'd0);
      bus_if.free_idx = 4'd3;
      tick();
      chk("stale_idx_av",   32'(bus_if.assign_valid), 32'd0);
      tick();
      chk("stale_idx_gate", 32'(bus_if.entry_gate_open), 32'd0);
      chk("stale_idx_slot", 32'(bus_if.assigned_slot), 32'd14);
      bus_if.entry_req = 1'b0;
      tick();

      bus_if.exit_valid = 1'b1;
      bus_if.exit_slot  = 4'd6;
      tick();
      bus_if.exit_valid = 1'b0;
      chk("exit6_cars",  32'(bus_if.cars), 32'h7FBF);
      chk("exit6_full",  32'(bus_if.full), 32'd0);
      chk("exit6_count", 32'(bus_if.occupied_count), 32'd14);
      chk("exit6_err",   32'(bus_if.exit_err), 32'd0);

      // Invalid exits: a slot that is already empty, then slot 15.
      bus_if.exit_valid = 1'b1;
      tick();
      bus_if.exit_valid = 1'b0;
      chk("bad6_err",   32'(bus_if.exit_err), 32'd1);
      chk("bad6_cars",  32'(bus_if.cars), 32'h7FBF);
      chk("bad6_count", 32'(bus_if.occupied_count), 32'd14);
      tick();
      chk("bad6_pulse", 32'(bus_if.exit_err), 32'd0);
      bus_if.exit_valid = 1'b1;
      bus_if.exit_slot  = 4'd15;
      tick();
      bus_if.exit_valid = 1'b0;
      chk("bad15_err",   32'(bus_if.exit_err), 32'd1);
      chk("bad15_cars",  32'(bus_if.cars), 32'h7FBF);
      chk("bad15_count", 32'(bus_if.occupied_count), 32'd14);
      tick();
      chk("bad15_pulse", 32'(bus_if.exit_err), 32'd0);

      // Build cars = 15'h0203, then allocate slot 2 while slot 9 leaves.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      admit(4'd0);
      admit(4'd1);
      admit(4'd9);
      chk("pre_cars", 32'(bus_if.cars), 32'h0203);
      bus_if.entry_req  = 1'b1;
      bus_if.free_idx   = 4'd2;
      bus_if.exit_valid = 1'b1;
      bus_if.exit_slot  = 4'd9;
      tick();
      chk("both_cars",  32'(bus_if.cars), 32'h0007);
      chk("both_count", 32'(bus_if.occupied_count), 32'd3);
      chk("both_av",    32'(bus_if.assign_valid), 32'd1);
      chk("both_slot",  32'(bus_if.assigned_slot), 32'd2);
      chk("both_err",   32'(bus_if.exit_err), 32'd0);
      settle();

      // An exit naming the slot being allocated is invalid, and the allocation still happens.
      bus_if.entry_req  = 1'b1;
      bus_if.free_idx   = 4'd3;
      bus_if.exit_valid = 1'b1;
      bus_if.exit_slot  = 4'd3;
      tick();
      chk("same_cars",  32'(bus_if.cars), 32'h000F);
      chk("same_count", 32'(bus_if.occupied_count), 32'd4);
      chk("same_err",   32'(bus_if.exit_err), 32'd1);
      chk("same_av",    32'(bus_if.assign_valid), 32'd1);
      settle();

      // Reset in the middle of GATE_OPEN.
      bus_if.entry_req = 1'b1;
      bus_if.free_idx  = 4'd4;
      tick();
      bus_if.entry_req = 1'b0;
      tick();
      tick();
      chk("mid_gate", 32'(bus_if.entry_gate_open), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_gate",  32'(bus_if.entry_gate_open), 32'd0);
      chk("mrst_cars",  32'(bus_if.cars), 32'h0);
      chk("mrst_count", 32'(bus_if.occupied_count), 32'd0);
      chk("mrst_slot",  32'(bus_if.assigned_slot), 32'd15);
      bus_if.entry_req = 1'b1;
      bus_if.free_idx  = 4'd0;
      tick();
      chk("post_av",   32'(bus_if.assign_valid), 32'd1);
      chk("post_slot", 32'(bus_if.assigned_slot), 32'd0);
      chk("post_cars", 32'(bus_if.cars), 32'h0001);
      chk("post_gate", 32'(bus_if.entry_gate_open), 32'd1);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Entry/exit controller for the 15-slot lot; owns the registered occupancy vector.
- Drives `cars[14:0]` into the first-free-slot finder and consumes its 4-bit index (15 = lot full).
- On an entry request it allocates the indicated slot, opens the entry gate for a fixed time, then waits for the car to clear.
- Exit events release slots.

Parameters:
- GATE_OPEN_CYCLES, default 8: number of clock cycles `entry_gate_open` stays high per admission (legal range 1..255).
- CNT_W, default 8: width of the internal gate timer (must hold GATE_OPEN_CYCLES).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- entry_req  input  1  level; car present at entry sensor
- free_idx  input  4  first empty slot index from finder; 4'd15 = no free slot
- exit_valid  input  1  one-cycle pulse; a car left slot `exit_slot`
- exit_slot  input  4  slot being vacated, valid with `exit_valid`
- cars  output  15  registered occupancy; bit i = 1 means slot i occupied
- entry_gate_open  output  1  entry barrier open command
- assigned_slot  output  4  last allocated slot; 4'd15 when none
- assign_valid  output  1  one-cycle pulse on allocation
- full  output  1  high when all 15 bits of `cars` are 1 (combinational from `cars`)
- occupied_count  output  4  registered population count of `cars`, 0..15
- exit_err  output  1  one-cycle pulse on an invalid exit

Behaviour:
- Reset (sampled at posedge):
  - `cars` = 0, `occupied_count` = 0, `assigned_slot` = 4'd15.
  - `assign_valid`, `entry_gate_open`, `exit_err` = 0; timer = 0; state = IDLE.
  - Reset mid-operation aborts any admission; the gate is low from the cycle after reset is sampled.
- States: IDLE, GATE_OPEN, WAIT_CLEAR.
- IDLE:
  - If `entry_req`=1, `free_idx`<15 and `cars[free_idx]`=0: at the same edge set `cars[free_idx]`, `assigned_slot`<=`free_idx`, `assign_valid`<=1 for one cycle, timer<=GATE_OPEN_CYCLES-1, go to GATE_OPEN.
  - Otherwise stay in IDLE. This covers `free_idx`=15, and an inconsistent index whose `cars` bit is already set; in both cases nothing is allocated.
- GATE_OPEN:
  - `entry_gate_open`=1 (registered, high exactly GATE_OPEN_CYCLES cycles, starting the cycle after allocation).
  - Timer decrements each cycle; at 0 go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Gate low; stay until `entry_req`=0, then go to IDLE.
  - This guarantees one allocation per car even if the sensor stays high.
- Exit handling (independent of FSM state, every cycle):
  - If `exit_valid`=1, `exit_slot`<15 and `cars[exit_slot]`=1: clear that bit at the edge.
  - Otherwise pulse `exit_err` next cycle with no state change. This covers slot 15 and already-empty slots.
- Simultaneous allocation and valid exit in the same cycle:
  - Both updates apply; `occupied_count` net change 0.
  - The slots are necessarily distinct, since the allocated slot was empty.
  - If `exit_slot`==`free_idx`, that exit is invalid (`exit_err`) and allocation proceeds.
- `occupied_count` is +1 on allocation and -1 on valid exit; it never wraps, because allocation requires a free bit and exit requires a set bit.
- `free_idx` is consumed in the same cycle that `cars` is presented (finder is combinational); there is no extra pipeline stage.
- `assigned_slot` holds its value until the next allocation or reset.

Test Plan:
- Reset, empty lot, `free_idx`=0, `entry_req`=1 for 20 cycles:
  - `assign_valid` pulse with `assigned_slot`=0, `cars`=15'h0001, `occupied_count`=1.
  - Gate high exactly 8 cycles; no second allocation while `entry_req` stays high.
  - `entry_req`=0 returns FSM to IDLE.
- Fill 15 slots sequentially, each with its own `entry_req` pulse:
  - `cars`=15'h7FFF, `full`=1, `occupied_count`=15.
  - Further `entry_req` with `free_idx`=15 gives no `assign_valid` and gate stays 0.
- With `cars`=15'h7FFF, `exit_valid` with `exit_slot`=6: next cycle `cars`=15'h7FBF, `full`=0, `occupied_count`=14.
- `exit_valid` with `exit_slot`=6 while slot 6 is empty, and separately `exit_slot`=15: one `exit_err` pulse each; `cars` and `occupied_count` unchanged.
- Same-cycle allocation into slot 2 and valid exit from slot 9 (`cars` was 15'h0203):
  - Result `cars`=15'h0007, `occupied_count` unchanged at 3.
- Assert `rst` for 1 cycle during GATE_OPEN:
  - Next cycle gate=0, `cars`=0, `occupied_count`=0, `assigned_slot`=15.
  - A new `entry_req` allocates slot 0 normally.
